ser_tx: RTL and testbench
=========================

Name: ser_tx

Overview:
Parallel-to-serial converter that feeds the serial `din` input of the downstream sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake into a one-word holding register.
- Shifts each word out one bit per clock, with a qualifying valid.
- Streams back-to-back words with no idle cycle between them, so the detector sees a continuous bitstream.

Parameters:
WIDTH, 8, word width in bits; legal range 2 or more.
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
rst_n  in  1  asynchronous, active-low reset.
clr  in  1  synchronous abort; discards the held word and the word in flight.
din_par  in  WIDTH  parallel word to send.
load  in  1  din_par is valid this cycle.
ready  out  1  holding register empty; a word is accepted on an edge where load=1 and ready=1.
dout  out  1  serial bit, registered; drives the detector's din.
dout_vld  out  1  dout carries a valid bit this cycle.
word_done  out  1  one-cycle pulse, coincident with the last bit of each word.
busy  out  1  shifter active or holding register full.

Behaviour:
- Reset: while rst_n=0, every register clears immediately, with no clock edge needed.
  - State=IDLE, hold_full=0, bit counter=0.
  - dout=0, dout_vld=0, word_done=0, busy=0.
  - ready reads 1.
- ready = !hold_full, decoded directly from a register. It is not combinationally dependent on load.
- Accept: on an edge where load & ready, hold <= din_par and hold_full <= 1.
  - A load while ready=0 is ignored: no capture, no error.
  - ready does not rise in the same cycle that hold drains. A new load is accepted from the next cycle onward.
- State register is one-hot, with states IDLE and SHIFT.
- IDLE:
  - dout=0, dout_vld=0.
  - If hold_full, at the next edge: shifter <= hold, hold_full <= 0, count <= 0, state <= SHIFT.
  - dout/dout_vld then present the first bit after that edge.
- SHIFT:
  - Each edge advances one bit: left shift if MSB_FIRST=1, right shift otherwise. count increments.
  - dout_vld=1 for exactly WIDTH consecutive cycles per word.
  - word_done=1 during the cycle dout carries the last bit (count = WIDTH-1).
- End of word, evaluated at the edge leaving the last bit:
  - If hold_full: reload shifter from hold, clear hold_full, count <= 0, stay in SHIFT. The next word's first bit follows immediately, with no gap.
  - Otherwise: go to IDLE, dout <= 0, dout_vld <= 0.
- Latency: a word accepted at edge t0 reaches the shifter at edge t1. Its first bit is valid t1..t2 and its last bit is valid t(WIDTH)..t(WIDTH+1).
- Throughput: one bit per clock while upstream keeps hold filled. hold must be loaded at least one cycle before the current word's last-bit edge.
- clr (sampled on edge, priority over load and over the shift/reload):
  - State <= IDLE, hold_full <= 0.
  - dout <= 0, dout_vld <= 0, word_done <= 0.
  - A load asserted in the same cycle as clr is dropped.
- busy = (state==SHIFT) | hold_full.
- Counter width: $clog2(WIDTH). The counter never wraps past WIDTH-1.
- Mid-word reset: asynchronous clear as above. No partial word resumes after release.

Decomposition:
- Shared package: one-hot state encodings (IDLE, SHIFT) and the default WIDTH constant. The downstream detector's testbench also uses these.
- No sub-module. Holding register, shifter, counter and FSM stay in one module of about 150 lines.

Test Plan (WIDTH=8):
- Reset: assert rst_n=0 mid-cycle with no clock edge -> dout=0, dout_vld=0, busy=0 immediately; ready=1 after release.
- Single word: load 8'hB4 at t0, MSB_FIRST=1 -> dout = 1,0,1,1,0,1,0,0 over t1..t8; dout_vld high exactly 8 cycles; word_done only in the t8 cycle; IDLE afterwards.
- Back-to-back: load 8'hFF, then 8'h0F once ready returns -> 16 contiguous dout_vld cycles, bits 11111111 00001111; ready=0 while hold is full; two word_done pulses 8 cycles apart.
- Overrun: hold load=1 continuously with a new value every cycle -> only values present while ready=1 are sent; none are duplicated or corrupted.
- clr after the 3rd bit of 8'hA5, with a second word held -> next cycle dout_vld=0, ready=1, busy=0; neither word emits further bits.
- MSB_FIRST=0: load 8'hB4 -> dout = 0,0,1,0,1,1,0,1. End-to-end: stream 8'hB6 into the detector -> its flag asserts on the expected pattern positions.

Source files
------------

// File: rtl/ser_tx_pkg.sv
// Shared definitions for the serializer and the downstream detector bench.
package ser_tx_pkg;
   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b01,
      ST_SHIFT = 2'b10
   } state_t;
endpackage

// File: rtl/ser_tx_if.sv
// Parallel load handshake plus serial output bundle of the serializer.
interface ser_tx_if #(parameter int WIDTH = 8);
   logic [WIDTH-1:0] din_par;
   logic             load;
   logic             ready;
   logic             dout;
   logic             dout_vld;
   logic             word_done;
   logic             busy;

   modport master (output din_par, load,
                   input  ready, dout, dout_vld, word_done, busy);
   modport slave  (input  din_par, load,
                   output ready, dout, dout_vld, word_done, busy);
endinterface

// File: rtl/ser_tx.sv
// Parallel-to-serial converter: one-word holding register feeding a shifter,
// reloading on the last-bit edge so consecutive words stream without a gap.
module ser_tx
   import ser_tx_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     clr,
   ser_tx_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_hold, r_shift, w_shift_nxt;
   logic             r_hold_full;
   logic [CW-1:0]    r_cnt;
   logic             w_last, w_take, w_accept, w_vld, w_done;

   assign w_last   = (r_state == ST_SHIFT) && (r_cnt == CW'(WIDTH-1));
   // hold drains into the shifter from IDLE or on the last-bit edge
   assign w_take   = r_hold_full && ((r_state == ST_IDLE) || w_last);
   assign w_accept = bus.load && !r_hold_full;
   assign w_shift_nxt = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                  : {1'b0, r_shift[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (clr) begin
         w_next = ST_IDLE;
      end else begin
         unique case (r_state)
            ST_IDLE:  if (r_hold_full) w_next = ST_SHIFT;
            ST_SHIFT: if (w_last && !r_hold_full) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_vld  = 1'b0;
      w_done = 1'b0;
      unique case (r_state)
         ST_SHIFT: begin
            w_vld  = 1'b1;
            w_done = w_last;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_shift     <= '0;
         r_cnt       <= '0;
      end else if (clr) begin
         r_hold_full <= 1'b0;
         r_shift     <= '0;
         r_cnt       <= '0;
      end else begin
         if (w_take) begin
            r_shift     <= r_hold;
            r_cnt       <= '0;
            r_hold_full <= 1'b0;
         end else if (r_state == ST_SHIFT) begin
            // shifter is zeroed on exit so dout idles low
            r_shift <= w_last ? '0 : w_shift_nxt;
            r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
         end
         if (w_accept) begin
            r_hold      <= bus.din_par;
            r_hold_full <= 1'b1;
         end
      end
   end

   assign bus.ready     = !r_hold_full;
   assign bus.dout      = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
   assign bus.dout_vld  = w_vld;
   assign bus.word_done = w_done;
   assign bus.busy      = (r_state == ST_SHIFT) || r_hold_full;
endmodule

// File: tb/tb_ser_tx.sv
// Directed bench for ser_tx: MSB-first and LSB-first instances share stimulus
// and are checked each cycle against a word/bits-remaining model.
module tb_ser_tx;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clr = 1'b0;
   logic load = 1'b0;
   logic [W-1:0] din = '0;

   always #5 clk = ~clk;

   ser_tx_if #(.WIDTH(W)) b0 ();
   ser_tx_if #(.WIDTH(W)) b1 ();
   assign b0.load = load;  assign b0.din_par = din;
   assign b1.load = load;  assign b1.din_par = din;

   ser_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(b0));
   ser_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(b1));

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // model: a word currently being sent (bits remaining) plus an optional held word
   logic [W-1:0] mw [2];
   logic [W-1:0] mh [2];
   int           mrem [2];
   bit           mf [2];

   always @(negedge rst_n) begin
      for (int i = 0; i < 2; i++) begin mrem[i] = 0; mf[i] = 0; end
   end

   always @(posedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 2; i++) begin
            if (clr) begin
               mrem[i] = 0; mf[i] = 0;
            end else begin
               bit rdy, take;
               rdy  = !mf[i];
               take = mf[i] && (mrem[i] <= 1);
               if (mrem[i] > 0) mrem[i]--;
               if (take) begin mw[i] = mh[i]; mrem[i] = W; mf[i] = 0; end
               if (load && rdy) begin mh[i] = din; mf[i] = 1; end
            end
         end
      end
   end

   function automatic logic mbit(input int i);
      int p;
      p = W - mrem[i];
      return (i == 0) ? mw[i][W-1-p] : mw[i][p];
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         chk("u0.ready", 32'(b0.ready),     32'(!mf[0]));
         chk("u0.vld",   32'(b0.dout_vld),  32'(mrem[0] > 0));
         chk("u0.done",  32'(b0.word_done), 32'(mrem[0] == 1));
         chk("u0.busy",  32'(b0.busy),      32'((mrem[0] > 0) || mf[0]));
         chk("u0.dout",  32'(b0.dout),      32'((mrem[0] > 0) ? mbit(0) : 1'b0));
         chk("u1.ready", 32'(b1.ready),     32'(!mf[1]));
         chk("u1.vld",   32'(b1.dout_vld),  32'(mrem[1] > 0));
         chk("u1.done",  32'(b1.word_done), 32'(mrem[1] == 1));
         chk("u1.busy",  32'(b1.busy),      32'((mrem[1] > 0) || mf[1]));
         chk("u1.dout",  32'(b1.dout),      32'((mrem[1] > 0) ? mbit(1) : 1'b0));
      end
   end

   // capture of the serial streams for literal checks
   logic [15:0] cap0, cap1;
   int run, maxrun, nd0, cyc, lastd, gap;
   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (b0.dout_vld) begin
            cap0 = {cap0[14:0], b0.dout};
            run++;
            if (run > maxrun) maxrun = run;
         end else run = 0;
         if (b1.dout_vld) cap1 = {cap1[14:0], b1.dout};
         if (b0.word_done) begin
            if (nd0 > 0) gap = cyc - lastd;
            lastd = cyc;
            nd0++;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clr_caps();
      cap0 = '0; cap1 = '0; run = 0; maxrun = 0; nd0 = 0; gap = 0;
   endtask

   initial begin
      int k;
      // reset and release
      #12; rst_n = 1'b1;
      @(negedge clk); #1;
      chk("rst.ready", 32'(b0.ready), 32'd1);
      chk("rst.busy",  32'(b0.busy),  32'd0);

      // single word B4, latency to word_done
      tick(); clr_caps();
      load = 1'b1; din = 8'hB4;
      tick(); load = 1'b0;
      k = 0;
      @(negedge clk);
      while (!b0.word_done && k < 30) begin @(negedge clk); k++; end
      chk("b4.latency", 32'(k), 32'd8);
      repeat (4) tick();
      chk("b4.msb",   32'(cap0[7:0]), 32'hB4);
      chk("b4.lsb",   32'(cap1[7:0]), 32'h2D);
      chk("b4.run",   32'(maxrun),    32'd8);
      chk("b4.ndone", 32'(nd0),       32'd1);
      chk("b4.idle",  32'(b0.busy),   32'd0);

      // back-to-back FF, 0F
      clr_caps();
      load = 1'b1; din = 8'hFF;
      tick();
      din = 8'h0F;
      k = 0;
      while (!b0.ready && k < 20) begin tick(); k++; end
      tick(); load = 1'b0;
      chk("b2b.rdy_low", 32'(b0.ready), 32'd0);
      repeat (22) tick();
      chk("b2b.msb",   32'(cap0), 32'hFF0F);
      chk("b2b.lsb",   32'(cap1), 32'hFFF0);
      chk("b2b.run",   32'(maxrun), 32'd16);
      chk("b2b.ndone", 32'(nd0), 32'd2);
      chk("b2b.gap",   32'(gap), 32'd8);

      // overrun: new value every cycle, model decides which are taken
      load = 1'b1;
      for (int i = 0; i < 40; i++) begin din = 8'(8'h31 * i + 8'h5A); tick(); end
      load = 1'b0;
      repeat (20) tick();

      // clr after the third bit of A5 with 3C held
      load = 1'b1; din = 8'hA5;
      tick();
      din = 8'h3C;
      repeat (3) tick();
      load = 1'b0;
      chk("clr.held", 32'(b0.ready), 32'd0);
      k = 0;
      begin
         int nb;
         nb = 0;
         while (nb < 3 && k < 30) begin
            @(negedge clk); k++;
            if (b0.dout_vld) nb++;
         end
      end
      clr = 1'b1;
      load = 1'b1; din = 8'h77;
      @(posedge clk); #1;
      clr = 1'b0; load = 1'b0;
      @(negedge clk);
      chk("clr.vld",   32'(b0.dout_vld), 32'd0);
      chk("clr.ready", 32'(b0.ready),    32'd1);
      chk("clr.busy",  32'(b0.busy),     32'd0);
      clr_caps();
      repeat (20) tick();
      chk("clr.silent", 32'(nd0 + maxrun), 32'd0);

      // asynchronous reset in the middle of a word
      load = 1'b1; din = 8'hC3;
      tick(); load = 1'b0;
      repeat (4) tick();
      #2; rst_n = 1'b0;
      #1;
      chk("arst.vld",   32'(b0.dout_vld), 32'd0);
      chk("arst.dout",  32'(b0.dout),     32'd0);
      chk("arst.busy",  32'(b0.busy),     32'd0);
      chk("arst.ready", 32'(b0.ready),    32'd1);
      repeat (2) tick();
      #2; rst_n = 1'b1;
      tick(); clr_caps();
      repeat (12) tick();
      chk("arst.silent", 32'(nd0 + maxrun), 32'd0);

      // stream B6 in both bit orders
      clr_caps();
      load = 1'b1; din = 8'hB6;
      tick(); load = 1'b0;
      repeat (12) tick();
      chk("b6.msb", 32'(cap0[7:0]), 32'hB6);
      chk("b6.lsb", 32'(cap1[7:0]), 32'h6D);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
